mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave memory arbiter between the instruction fetch unit and the load/store unit of the multi-cycle core. Both units share a single memory port. Grants are registered and round-robin, and exactly one transaction is outstanding at a time. A response watchdog returns an error if the slave never answers.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (byte mask is DW/8)
- TIMEOUT, 1023, max cycles waiting for slave response; 0 disables watchdog

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- ifu_req_valid / ifu_req_ready  in / out  1  IFU read request handshake
- ifu_req_addr  in  AW  IFU fetch address
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_resp_rdata  out  DW  fetched word
- ifu_resp_err  out  1  slave error or timeout
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_addr  in  AW  LSU address
- lsu_req_wdata  in  DW  write data
- lsu_req_wmask  in  DW/8  byte write mask
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake
- lsu_resp_rdata  out  DW  read data; don't-care for writes
- lsu_resp_err  out  1  slave error or timeout
- mem_req_valid / mem_req_ready  out / in  1  slave request handshake
- mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/AW/DW/DW/8  forwarded request fields
- mem_resp_valid / mem_resp_ready  in / out  1  slave response handshake
- mem_resp_rdata  in  DW  slave read data
- mem_resp_err  in  1  slave error

## Operation
- A handshake completes on any cycle where valid=1 and ready=1 at the rising edge.
- Registered state:
  - FSM state: IDLE, REQ, RESP.
  - owner: IFU or LSU.
  - last: the master granted most recently.
  - 16-bit watchdog counter wdog.
  - to_flag: timeout in progress.
- IDLE:
  - All ready/valid outputs are 0, and all mem_req fields are 0.
  - If exactly one master has req_valid=1, set owner to that master and go to REQ.
  - If both have req_valid=1, owner is the master that is not last. last resets to IFU, so LSU wins the first tie.
  - When owner is set, last is set to the same master.
- REQ:
  - mem_req_valid and all mem_req fields are driven combinationally from owner.
  - IFU requests force wen=0, wdata=0, wmask=0.
  - owner's req_ready = mem_req_ready; the other master's req_ready = 0.
  - On the mem_req handshake, go to RESP and clear wdog.
  - If owner's req_valid drops before the handshake (protocol violation), return to IDLE with no transaction.
- RESP:
  - mem_resp_ready = owner's resp_ready.
  - owner's resp_valid, rdata and err are driven combinationally from mem_resp_*.
  - The non-owner sees resp_valid=0.
  - On the owner's resp handshake, go to IDLE.
  - wdog increments every RESP cycle without mem_resp_valid.
- Timeout: when TIMEOUT≠0 and wdog reaches TIMEOUT:
  - Set to_flag.
  - mem_resp_ready goes to 0.
  - Owner sees resp_valid=1, err=1, rdata=0 until it accepts.
  - Then go to IDLE and clear to_flag.
  - A late slave response is not forwarded to either master.
- The non-owner master's requests are held off (ready=0) until the arbiter returns to IDLE; they are never dropped.
- Reset (rstn=0 at an edge), at any state including mid-transaction:
  - state=IDLE, owner=IFU, last=IFU, wdog=0, to_flag=0.
  - All outputs read 0 in the cycle after reset.
  - An in-flight slave transaction is abandoned.

## Timing
- Arbitration costs one cycle: mem_req_valid rises 1 cycle after the master's req_valid is sampled in IDLE.
- Best case, with a slave that is always ready and responds the cycle after accept:
  - req accepted at cycle N+1;
  - resp at N+2;
  - arbiter in IDLE at N+3;
  - next grant at N+3, request issued at N+4.
- Back-to-back transactions from one master therefore start every 3 cycles minimum.
- No combinational path from any master input to the other master's outputs.
- Master-input-to-mem-output paths exist only through the owner mux.
- Timeout error is presented on the cycle after wdog==TIMEOUT is registered.

## Test plan
- Reset then single IFU read at addr 0x80000000, slave returns 0x00000413 one cycle after accept:
  - mem_req_valid rises at cycle 2;
  - ifu_resp_rdata=0x00000413 with err=0;
  - lsu outputs stay 0 throughout.
- IFU and LSU both assert in the same IDLE cycle, three times in a row:
  - grants go LSU, IFU, LSU;
  - each master's resp appears only on its own port.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, slave mem_req_ready low for 4 cycles:
  - fields stable on mem_req_* for all 4 cycles;
  - lsu_req_ready high only on the accept cycle.
- TIMEOUT=8, slave never responds to an IFU read:
  - ifu_resp_valid=1, err=1, rdata=0 on the 9th RESP cycle;
  - later slave response is ignored;
  - the next LSU request is granted normally.
- rstn=0 during RESP of an LSU read:
  - all outputs are 0 the next cycle;
  - after release, a fresh tie is won by LSU.
- Master holds resp_ready=0 for 3 cycles:
  - mem_resp_ready=0 for those cycles;
  - resp data held;
  - completes on the 4th cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter.
// Registered round-robin grant, one outstanding transaction, and a response
// watchdog that answers the owner with an error if the slave stays silent.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising edge where valid=1 and ready=1; a master holds valid and its
// payload stable until that edge.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rstn,
  // instruction fetch unit
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_resp_rdata,
  output logic            ifu_resp_err,
  // load/store unit
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_req_wen,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wmask,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_resp_rdata,
  output logic            lsu_resp_err,
  // shared slave port
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [DW-1:0]   mem_resp_rdata,
  input  logic            mem_resp_err,
  // debug visibility of the arbiter FSM
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);
  localparam logic        WDOG_ON    = (TIMEOUT != 0);

  logic [1:0]  state;
  logic        owner;
  logic        last;
  logic [15:0] wdog;
  logic        to_flag;

  logic        grant;
  logic        own_req_valid;
  logic        own_resp_ready;
  logic        timed_out;
  logic        resp_valid_mux;
  logic [DW-1:0] resp_rdata_mux;
  logic        resp_err_mux;
  logic        resp_hs;

  // Owner muxes, round-robin pick and the watchdog/timeout response source.
  always_comb begin
    // On a tie the master that was not granted last wins.
    grant          = (ifu_req_valid && lsu_req_valid) ? ~last : lsu_req_valid;
    own_req_valid  = (owner == OWN_LSU) ? lsu_req_valid  : ifu_req_valid;
    own_resp_ready = (owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    // The error is raised in the same cycle wdog is seen at the limit, and
    // to_flag keeps it up until the owner takes it.
    timed_out      = WDOG_ON && (state == S_RESP) &&
                     (to_flag || (wdog == WDOG_LIMIT));
    resp_valid_mux = timed_out ? 1'b1 : mem_resp_valid;
    resp_rdata_mux = timed_out ? '0   : mem_resp_rdata;
    resp_err_mux   = timed_out ? 1'b1 : mem_resp_err;
    resp_hs        = (state == S_RESP) && resp_valid_mux && own_resp_ready;
  end

  // Output steering: everything is quiet in IDLE; only the owner is connected otherwise.
  always_comb begin
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    ifu_resp_err   = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_wen    = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    mem_req_wmask  = '0;
    mem_resp_ready = 1'b0;
    case (state)
      S_REQ: begin
        mem_req_valid = own_req_valid;
        if (owner == OWN_LSU) begin
          mem_req_wen   = lsu_req_wen;
          mem_req_addr  = lsu_req_addr;
          mem_req_wdata = lsu_req_wdata;
          mem_req_wmask = lsu_req_wmask;
          lsu_req_ready = mem_req_ready;
        end else begin
          // Fetches are always reads with no write payload.
          mem_req_addr  = ifu_req_addr;
          ifu_req_ready = mem_req_ready;
        end
      end
      S_RESP: begin
        // After a timeout the slave is no longer listened to.
        mem_resp_ready = timed_out ? 1'b0 : own_resp_ready;
        if (owner == OWN_LSU) begin
          lsu_resp_valid = resp_valid_mux;
          lsu_resp_rdata = resp_rdata_mux;
          lsu_resp_err   = resp_err_mux;
        end else begin
          ifu_resp_valid = resp_valid_mux;
          ifu_resp_rdata = resp_rdata_mux;
          ifu_resp_err   = resp_err_mux;
        end
      end
      default: ;
    endcase
  end

  // FSM, grant bookkeeping and watchdog.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      owner   <= OWN_IFU;
      last    <= OWN_IFU;
      wdog    <= '0;
      to_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ifu_req_valid || lsu_req_valid) begin
            owner <= grant;
            last  <= grant;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!own_req_valid) begin
            // Owner withdrew its request: abandon without touching the slave.
            state <= S_IDLE;
          end else if (mem_req_ready) begin
            state <= S_RESP;
            wdog  <= '0;
          end
        end
        S_RESP: begin
          if (resp_hs) begin
            state   <= S_IDLE;
            to_flag <= 1'b0;
            wdog    <= '0;
          end else if (timed_out) begin
            to_flag <= 1'b1;
          end else if (!mem_resp_valid) begin
            wdog <= wdog + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios for latency, stall, timeout,
// reset and response back-pressure, then randomized traffic checked against
// a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_resp_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_resp_rdata;
  logic [MW-1:0] lsu_req_wmask;
  logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_rdata;
  logic [MW-1:0] mem_req_wmask;
  logic [1:0]    dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .dbg_state(dbg_state)
  );

  wire [140:0] all_outs = {ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
                           lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
                           mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
                           mem_req_wmask, mem_resp_ready};
  wire [34:0]  lsu_outs = {lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } txn_t;

  txn_t          ifu_q[$];
  txn_t          lsu_q[$];
  logic [DW+1:0] exp_q[$];    // {rdata_checked, err, rdata}
  bit            grant_log[$]; // 1 = LSU granted, 0 = IFU granted
  bit            m_busy, m_acc, m_owner, m_last;
  bit            ifu_go, lsu_go, ifu_wait, lsu_wait;
  bit            s_pend, s_err;
  int            s_cnt;
  logic [DW-1:0] s_rdata;
  int            n_done;
  int            go_pct, rdy_pct;

  // Data the slave returns for a read of address a; error flag is addr bit 3.
  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_clear(input bit last_grant);
    m_busy = 0; m_acc = 0; m_owner = 0; m_last = last_grant;
    ifu_go = 0; lsu_go = 0; ifu_wait = 0; lsu_wait = 0;
    s_pend = 0; s_cnt = 0; s_rdata = '0; s_err = 0; n_done = 0;
    exp_q.delete(); grant_log.delete(); ifu_q.delete(); lsu_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = '0; lsu_req_wdata = '0;
    lsu_req_wmask = '0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    model_clear(1'b0);
  endtask

  task automatic push_ifu();
    txn_t t;
    t = '0;
    t.addr = $urandom() & 32'hFFFF_FFFC;
    ifu_q.push_back(t);
  endtask

  task automatic push_lsu();
    txn_t t;
    t.wen   = 1'($urandom_range(0, 1));
    t.addr  = $urandom() & 32'hFFFF_FFFC;
    t.wdata = $urandom();
    t.wmask = 4'($urandom_range(0, 15));
    lsu_q.push_back(t);
  endtask

  // One clock of randomized traffic: drive masters and slave, check the DUT
  // against the model, then advance the model past the coming rising edge.
  task automatic engine_cycle();
    txn_t t;
    logic [DW+1:0] e;
    logic own_rv, oth_rv, own_rr;
    @(negedge clk);
    if (!ifu_go && !ifu_wait && ifu_q.size() > 0 && $urandom_range(0, 99) < go_pct) ifu_go = 1;
    if (!lsu_go && !lsu_wait && lsu_q.size() > 0 && $urandom_range(0, 99) < go_pct) lsu_go = 1;
    ifu_req_valid = ifu_go;
    ifu_req_addr  = ifu_go ? ifu_q[0].addr : '0;
    lsu_req_valid = lsu_go;
    if (lsu_go) {lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask} = lsu_q[0];
    else {lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask} = '0;
    ifu_resp_ready = ($urandom_range(0, 3) != 0);
    lsu_resp_ready = ($urandom_range(0, 3) != 0);
    mem_req_ready  = ($urandom_range(0, 99) < rdy_pct);
    mem_resp_valid = s_pend && (s_cnt == 0);
    mem_resp_rdata = mem_resp_valid ? s_rdata : '0;
    mem_resp_err   = mem_resp_valid && s_err;
    #1;
    if (!m_busy) begin
      check("idle_no_req", mem_req_valid, 0);
      check("idle_no_ready", {ifu_req_ready, lsu_req_ready}, 0);
      check("idle_no_resp", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 0);
    end else if (!m_acc) begin
      t = m_owner ? lsu_q[0] : ifu_q[0];
      check("req_valid", mem_req_valid, 1);
      check("req_fields", {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask}, t);
      check("req_ready_owner", m_owner ? lsu_req_ready : ifu_req_ready, mem_req_ready);
      check("req_ready_other", m_owner ? ifu_req_ready : lsu_req_ready, 0);
      check("req_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    end else begin
      own_rv = m_owner ? lsu_resp_valid : ifu_resp_valid;
      oth_rv = m_owner ? ifu_resp_valid : lsu_resp_valid;
      own_rr = m_owner ? lsu_resp_ready : ifu_resp_ready;
      check("resp_valid_owner", own_rv, mem_resp_valid);
      check("resp_valid_other", oth_rv, 0);
      check("resp_ready_fwd", mem_resp_ready, own_rr);
      check("resp_no_req", {mem_req_valid, ifu_req_ready, lsu_req_ready}, 0);
      if (mem_resp_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        check("resp_err", m_owner ? lsu_resp_err : ifu_resp_err, e[DW]);
        if (e[DW+1]) check("resp_rdata", m_owner ? lsu_resp_rdata : ifu_resp_rdata, e[DW-1:0]);
      end
    end
    // slave progress
    if (mem_resp_valid && mem_resp_ready) s_pend = 0;
    else if (s_pend && s_cnt > 0) s_cnt--;
    // arbitration rules
    if (!m_busy) begin
      if (ifu_req_valid || lsu_req_valid) begin
        m_owner = (ifu_req_valid && lsu_req_valid) ? !m_last : lsu_req_valid;
        m_last  = m_owner;
        m_busy  = 1;
        m_acc   = 0;
        grant_log.push_back(m_owner);
      end
    end else if (!m_acc) begin
      if (mem_req_ready) begin
        m_acc = 1;
        if (m_owner) begin t = lsu_q.pop_front(); lsu_go = 0; lsu_wait = 1; end
        else begin t = ifu_q.pop_front(); ifu_go = 0; ifu_wait = 1; end
        exp_q.push_back({!t.wen, t.addr[3], slave_data(t.addr)});
        s_pend  = 1;
        s_cnt   = $urandom_range(0, 2);
        s_rdata = mem_req_wen ? $urandom() : slave_data(mem_req_addr);
        s_err   = mem_req_addr[3];
      end
    end else if (mem_resp_valid && (m_owner ? lsu_resp_ready : ifu_resp_ready)) begin
      m_busy = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_owner) lsu_wait = 0; else ifu_wait = 0;
      n_done++;
    end
  endtask

  task automatic run_engine(input int max_cycles);
    int n = 0;
    while ((ifu_q.size() != 0 || lsu_q.size() != 0 || m_busy) && n < max_cycles) begin
      engine_cycle();
      n++;
    end
    check("engine_drained", {ifu_q.size() == 0, lsu_q.size() == 0, m_busy}, 3'b110);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rstn = 0;
    model_clear(1'b0);

    // Reset with busy-looking inputs: every output must still read 0.
    repeat (2) @(negedge clk);
    ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1;
    mem_resp_valid = 1; mem_resp_rdata = '1;
    @(negedge clk); #1;
    check("reset_outputs", all_outs, 0);
    check("reset_state", dbg_state, 0);
    clear_inputs();
    rstn = 1;

    // Single IFU read, slave answers one cycle after accept.
    @(negedge clk);
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    #1;
    check("ifu_rd_idle_req", mem_req_valid, 0);
    check("ifu_rd_lsu_quiet0", lsu_outs, 0);
    @(negedge clk); #1;
    check("ifu_rd_req_rise", mem_req_valid, 1);
    check("ifu_rd_fields", {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask},
          {1'b0, 32'h8000_0000, 32'h0, 4'h0});
    check("ifu_rd_req_ready", ifu_req_ready, 1);
    check("ifu_rd_lsu_quiet1", lsu_outs, 0);
    @(negedge clk);
    ifu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    #1;
    check("ifu_rd_resp", {ifu_resp_valid, ifu_resp_err, ifu_resp_rdata}, {1'b1, 1'b0, 32'h0000_0413});
    check("ifu_rd_mem_resp_ready", mem_resp_ready, 1);
    check("ifu_rd_lsu_quiet2", lsu_outs, 0);
    @(negedge clk);
    mem_resp_valid = 0; mem_resp_rdata = '0;
    #1;
    check("ifu_rd_done", all_outs, 0);

    // Three ties in a row: LSU, IFU, LSU.
    do_reset();
    repeat (3) begin push_ifu(); push_lsu(); end
    go_pct = 100; rdy_pct = 70;
    run_engine(300);
    check("tie_grant_count", grant_log.size(), 6);
    if (grant_log.size() >= 3)
      check("tie_order", {grant_log[0], grant_log[1], grant_log[2]}, 3'b101);

    // LSU write stalled by the slave for 4 cycles.
    do_reset();
    @(negedge clk);
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_1000;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; lsu_resp_ready = 1; mem_req_ready = 0;
    #1;
    check("wr_idle_ready", lsu_req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("wr_stall_fields", {mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask},
            {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF});
      check("wr_stall_ready", lsu_req_ready, 0);
    end
    @(negedge clk);
    mem_req_ready = 1;
    #1;
    check("wr_accept_ready", lsu_req_ready, 1);
    check("wr_accept_fields", {mem_req_valid, mem_req_addr}, {1'b1, 32'h8000_1000});
    @(negedge clk);
    lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1;
    #1;
    check("wr_resp", {lsu_resp_valid, lsu_resp_err, lsu_req_ready, mem_req_valid}, 4'b1000);
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    check("wr_done", all_outs, 0);

    // Watchdog: slave silent after accepting an IFU read.
    do_reset();
    @(negedge clk);
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040; mem_req_ready = 1; ifu_resp_ready = 1;
    @(negedge clk); #1;
    check("to_req", {mem_req_valid, ifu_req_ready}, 2'b11);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      ifu_req_valid = 0; mem_req_ready = 0;
      if (k == TO + 1) begin mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0_BAD0; end
      #1;
      if (k <= TO) begin
        check("to_wait_valid", ifu_resp_valid, 0);
        check("to_wait_ready", mem_resp_ready, 1);
      end else begin
        check("to_err_resp", {ifu_resp_valid, ifu_resp_err, ifu_resp_rdata}, {1'b1, 1'b1, 32'h0});
        check("to_mem_ready_low", mem_resp_ready, 0);
      end
    end
    @(negedge clk); #1;
    check("to_late_ignored", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready, dbg_state}, 0);
    @(negedge clk);
    mem_resp_valid = 0; mem_resp_rdata = '0;
    model_clear(1'b0);
    push_lsu();
    go_pct = 100; rdy_pct = 100;
    run_engine(50);
    check("to_next_lsu_done", n_done, 1);

    // Reset in the middle of an LSU read response phase.
    do_reset();
    @(negedge clk);
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_2000;
    mem_req_ready = 1; lsu_resp_ready = 1;
    @(negedge clk); #1;
    check("rst_req_ready", lsu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 0; mem_req_ready = 0;
    #1;
    check("rst_in_resp", {mem_resp_ready, lsu_resp_valid}, 2'b10);
    @(negedge clk);
    rstn = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    @(negedge clk); #1;
    check("rst_mid_outputs", all_outs, 0);
    check("rst_mid_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1; mem_resp_valid = 0; mem_resp_rdata = '0;
    model_clear(1'b0);
    push_ifu(); push_lsu();
    go_pct = 100; rdy_pct = 100;
    run_engine(50);
    check("rst_tie_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) check("rst_tie_lsu_first", grant_log[0], 1);

    // Owner holds resp_ready low for 3 cycles.
    do_reset();
    @(negedge clk);
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100; mem_req_ready = 1; ifu_resp_ready = 0;
    @(negedge clk);
    @(negedge clk);
    ifu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_0001;
    #1;
    check("hold_c0", {mem_resp_ready, ifu_resp_valid, ifu_resp_rdata}, {1'b0, 1'b1, 32'hCAFE_0001});
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); #1;
      check("hold_cn", {mem_resp_ready, ifu_resp_valid, ifu_resp_rdata}, {1'b0, 1'b1, 32'hCAFE_0001});
    end
    @(negedge clk);
    ifu_resp_ready = 1;
    #1;
    check("hold_release", {mem_resp_ready, ifu_resp_valid, ifu_resp_rdata}, {1'b1, 1'b1, 32'hCAFE_0001});
    @(negedge clk);
    mem_resp_valid = 0; mem_resp_rdata = '0;
    #1;
    check("hold_done", all_outs, 0);

    // Randomized mixed traffic.
    do_reset();
    for (int i = 0; i < 30; i++) begin push_ifu(); push_lsu(); end
    go_pct = 40; rdy_pct = 60;
    run_engine(3000);
    check("rand_done", n_done, 60);
    check("rand_exp_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #1000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
